countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Countdown-timer engine serving the COUNT mode of the clock top; it counts down, the opposite direction of the time-of-day counter.
- Holds a user-edited preset and a remaining-time register, both in the top's packed 20-bit BCD format {hou_h[1:0], hou_l[3:0], min_h[2:0], min_l[3:0], sec_h[2:0], sec_l[3:0]}.
- Decrements the remaining time once per 1 Hz tick and raises an expiry pulse/level for the light driver.
- Its time output feeds the existing seven-segment path unchanged.

Parameters:
- MAX_HOUR, 23, largest hour value accepted by the editor; hours range 0..MAX_HOUR.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge
- rstn  in  1  reset, synchronous, active-low
- tick_1hz  in  1  single-cycle enable pulse, once per second, synchronous to clk_sys
- active  in  1  high while top state is COUNT; buttons and start are ignored when low
- button  in  5  debounced one-hot pulses: UP=10000, LEFT=01000, MID=00100, DOWN=00010, RIGHT=00001; MID is ignored (owned by top)
- start  in  1  single-cycle start/pause/resume/acknowledge pulse from top
- time_out  out  20  preset in EDIT, remaining time in RUN/PAUSE/DONE
- cursor  out  3  edit digit index: 0=sec_l .. 5=hou_h
- tmr_state  out  2  EDIT=00, RUN=01, PAUSE=10, DONE=11
- expired  out  1  one-cycle pulse on entry to DONE
- ringing  out  1  high for the whole time tmr_state==DONE

Behaviour:
- Reset (rstn low at a clk_sys edge):
  - preset=0, remaining=0, cursor=0, state=EDIT, expired=0, ringing=0.
  - Reset applied mid-RUN clears everything on that same edge.
- Input gating:
  - button and start take effect only when active=1.
  - Ticks are always honoured, so the timer keeps running in the background when another mode is displayed.
- Cursor (EDIT only):
  - LEFT: cursor+1, 5 wraps to 0.
  - RIGHT: cursor-1, 0 wraps to 5.
  - Cursor resets to 0 on every exit from EDIT.
- Digit edit, EDIT only, register updates on the same edge as the button pulse:
  - UP: sec_l/min_l 9->0; sec_h/min_h 5->0; otherwise +1.
  - UP on hou_l: ->0 if 9, or if hou_h==2 and hou_l==3; otherwise +1.
  - UP on hou_h: ->0 if hou_h==2, or if hou_h==1 and hou_l>3; otherwise +1.
  - DOWN: sec_l/min_l 0->9; sec_h/min_h 0->5.
  - DOWN on hou_l: 0->(hou_h==2 ? 3 : 9).
  - DOWN on hou_h: 0->(hou_l>3 ? 1 : 2).
  - DOWN otherwise: -1.
  - preset never holds an hour above MAX_HOUR.
- State machine:
  - EDIT: start with preset!=0 loads remaining<=preset and enters RUN. start with preset==0 is ignored.
  - RUN: tick decrements remaining. start enters PAUSE. DOWN enters EDIT and discards remaining. UP/LEFT/RIGHT are ignored.
  - PAUSE: ticks are ignored. start returns to RUN. DOWN enters EDIT.
  - DONE: remaining=0 and ringing=1. start or any button pulse (active=1) enters EDIT; preset is retained for re-run.
- Decrement, BCD borrow chain:
  - sec_l 0->9 borrows from sec_h; sec_h 0->5 borrows from min_l; min_l 0->9; min_h 0->5; hou_l 0->9 borrows from hou_h.
  - No arithmetic wrap below zero.
  - A tick that takes remaining from 00:00:01 to 00:00:00 enters DONE on that edge; expired=1 for exactly that next cycle.
- Simultaneous events in RUN:
  - tick with start: decrement is applied and state goes to PAUSE; if the decrement reaches zero, DONE wins and start is dropped.
  - tick with DOWN: EDIT wins, decrement is irrelevant.
  - tick in EDIT or DONE: no effect.
- Latency: all outputs are registered. time_out reflects an edit or tick one clk_sys cycle after the input pulse.

Test Plan:
- Reset, then RIGHT once, UP once -> cursor=5, hou_h=1, time_out=20'h40000 (hou_h=1, rest 0); LEFT -> cursor=0.
- Preset 00:00:03 via UP x3 on cursor 0, then start, then 3 ticks -> time_out 3,2,1,0. expired is high one cycle after the 3rd tick; tmr_state=11 and ringing=1 persist; next start -> EDIT with time_out=preset 00:00:03.
- Preset 01:00:00, start, 1 tick -> remaining 00:59:59 (borrow through every digit).
- Preset 23:00:00 edit: UP on hou_l -> hou_l=0; with hou_l=4, DOWN on hou_h from 0 -> hou_h=1 (14).
- RUN at 00:00:10: start -> PAUSE; 5 ticks -> still 00:00:10; start, 1 tick -> 00:00:09. Tick and start in the same cycle at 00:00:01 -> DONE and not PAUSE.
- active=0 in RUN: buttons and start are ignored while ticks still decrement; rstn low mid-RUN -> all outputs 0, tmr_state=EDIT on the next edge.

Source files
------------

// File: rtl/countdown_timer.sv
// Countdown-timer engine for the clock's COUNT mode: edits a BCD preset, counts the
// remaining time down once per 1 Hz tick and signals expiry to the light driver.
module countdown_timer #(
   parameter int MAX_HOUR = 23
) (
   input  logic        clk_sys,
   input  logic        rstn,
   input  logic        tick_1hz,
   input  logic        active,
   input  logic [4:0]  button,
   input  logic        start,
   output logic [19:0] time_out,
   output logic [2:0]  cursor,
   output logic [1:0]  tmr_state,
   output logic        expired,
   output logic        ringing
);

   typedef enum logic [1:0] {
      EDIT  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   // Hour limits split into BCD digits: tens of the top hour and its units digit.
   localparam logic [1:0] HH_MAX = 2'(MAX_HOUR / 10);
   localparam logic [3:0] HL_TOP = 4'(MAX_HOUR % 10);

   state_t      state, state_n;
   logic [19:0] preset, preset_n;
   logic [19:0] remain, remain_n;
   logic [19:0] remain_dec;
   logic [2:0]  cursor_n;
   logic        btn_up, btn_left, btn_down, btn_right, btn_any, go;

   function automatic logic [19:0] edit_digit(input logic [19:0] t, input logic [2:0] pos,
                                              input logic up);
      logic [3:0] sl, ml, hl;
      logic [2:0] sh, mh;
      logic [1:0] hh;
      {hh, hl, mh, ml, sh, sl} = t;
      case (pos)
         3'd0: sl = up ? ((sl == 4'd9) ? 4'd0 : sl + 4'd1) : ((sl == 4'd0) ? 4'd9 : sl - 4'd1);
         3'd1: sh = up ? ((sh == 3'd5) ? 3'd0 : sh + 3'd1) : ((sh == 3'd0) ? 3'd5 : sh - 3'd1);
         3'd2: ml = up ? ((ml == 4'd9) ? 4'd0 : ml + 4'd1) : ((ml == 4'd0) ? 4'd9 : ml - 4'd1);
         3'd3: mh = up ? ((mh == 3'd5) ? 3'd0 : mh + 3'd1) : ((mh == 3'd0) ? 3'd5 : mh - 3'd1);
         3'd4: begin
            if (up)
               hl = (hl == 4'd9 || (hh == HH_MAX && hl == HL_TOP)) ? 4'd0 : hl + 4'd1;
            else
               hl = (hl == 4'd0) ? ((hh == HH_MAX) ? HL_TOP : 4'd9) : hl - 4'd1;
         end
         3'd5: begin
            // The tens digit is wrapped so that the hour never exceeds MAX_HOUR.
            if (up)
               hh = (hh == HH_MAX || (hh == HH_MAX - 2'd1 && hl > HL_TOP)) ? 2'd0 : hh + 2'd1;
            else
               hh = (hh == 2'd0) ? ((hl > HL_TOP) ? HH_MAX - 2'd1 : HH_MAX) : hh - 2'd1;
         end
         default: ;
      endcase
      return {hh, hl, mh, ml, sh, sl};
   endfunction

   function automatic logic [19:0] bcd_dec(input logic [19:0] t);
      logic [3:0] sl, ml, hl;
      logic [2:0] sh, mh;
      logic [1:0] hh;
      logic       b;
      {hh, hl, mh, ml, sh, sl} = t;
      b = (t != 20'h0);
      if (b) begin if (sl == 4'd0) sl = 4'd9; else begin sl = sl - 4'd1; b = 1'b0; end end
      if (b) begin if (sh == 3'd0) sh = 3'd5; else begin sh = sh - 3'd1; b = 1'b0; end end
      if (b) begin if (ml == 4'd0) ml = 4'd9; else begin ml = ml - 4'd1; b = 1'b0; end end
      if (b) begin if (mh == 3'd0) mh = 3'd5; else begin mh = mh - 3'd1; b = 1'b0; end end
      if (b) begin if (hl == 4'd0) hl = 4'd9; else begin hl = hl - 4'd1; b = 1'b0; end end
      if (b) hh = hh - 2'd1;
      return {hh, hl, mh, ml, sh, sl};
   endfunction

   assign btn_up    = active & button[4];
   assign btn_left  = active & button[3];
   assign btn_down  = active & button[1];
   assign btn_right = active & button[0];
   assign btn_any   = active & |(button & 5'b11011);
   assign go        = active & start;
   assign remain_dec = bcd_dec(remain);

   always_comb begin
      state_n  = state;
      preset_n = preset;
      remain_n = remain;
      cursor_n = cursor;
      case (state)
         EDIT: begin
            if (go && preset != 20'h0) begin
               state_n  = RUN;
               remain_n = preset;
            end else if (btn_left) begin
               cursor_n = (cursor == 3'd5) ? 3'd0 : cursor + 3'd1;
            end else if (btn_right) begin
               cursor_n = (cursor == 3'd0) ? 3'd5 : cursor - 3'd1;
            end else if (btn_up || btn_down) begin
               preset_n = edit_digit(preset, cursor, btn_up);
            end
         end
         RUN: begin
            // DOWN beats everything; reaching zero beats a simultaneous pause request.
            if (btn_down) begin
               state_n  = EDIT;
               remain_n = 20'h0;
            end else begin
               if (tick_1hz) remain_n = remain_dec;
               if (tick_1hz && remain_dec == 20'h0) state_n = DONE;
               else if (go) state_n = PAUSE;
            end
         end
         PAUSE: begin
            if (btn_down) begin
               state_n  = EDIT;
               remain_n = 20'h0;
            end else if (go) begin
               state_n = RUN;
            end
         end
         DONE: begin
            if (go || btn_any) state_n = EDIT;
         end
         default: state_n = EDIT;
      endcase
      if (state_n != EDIT) cursor_n = 3'd0;
   end

   always_ff @(posedge clk_sys) begin
      if (!rstn) begin
         state    <= EDIT;
         preset   <= 20'h0;
         remain   <= 20'h0;
         cursor   <= 3'd0;
         time_out <= 20'h0;
         expired  <= 1'b0;
         ringing  <= 1'b0;
      end else begin
         state    <= state_n;
         preset   <= preset_n;
         remain   <= remain_n;
         cursor   <= cursor_n;
         time_out <= (state_n == EDIT) ? preset_n : remain_n;
         expired  <= (state_n == DONE) && (state != DONE);
         ringing  <= (state_n == DONE);
      end
   end

   assign tmr_state = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a vector table walked cycle by cycle plus
// hand-written sequences for hour editing, borrow propagation and mid-run reset.
module tb_countdown_timer;

   logic        clk_sys = 1'b0;
   logic        rstn;
   logic        tick_1hz;
   logic        active;
   logic [4:0]  button;
   logic        start;
   logic [19:0] time_out;
   logic [2:0]  cursor;
   logic [1:0]  tmr_state;
   logic        expired;
   logic        ringing;

   localparam logic [4:0] NB  = 5'b00000;
   localparam logic [4:0] UP  = 5'b10000;
   localparam logic [4:0] LF  = 5'b01000;
   localparam logic [4:0] MID = 5'b00100;
   localparam logic [4:0] DN  = 5'b00010;
   localparam logic [4:0] RT  = 5'b00001;

   typedef struct {
      logic        act;
      logic        tick;
      logic        go;
      logic [4:0]  btn;
      logic [19:0] t;
      logic [2:0]  cur;
      logic [1:0]  st;
      logic        ex;
      logic        ring;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   countdown_timer #(.MAX_HOUR(23)) dut (
      .clk_sys  (clk_sys),
      .rstn     (rstn),
      .tick_1hz (tick_1hz),
      .active   (active),
      .button   (button),
      .start    (start),
      .time_out (time_out),
      .cursor   (cursor),
      .tmr_state(tmr_state),
      .expired  (expired),
      .ringing  (ringing)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input logic [19:0] got, input logic [19:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic check_all(input string name, input logic [19:0] t, input logic [2:0] cur,
                            input logic [1:0] st, input logic ex, input logic ring);
      chk({name, ".time"}, time_out, t);
      chk({name, ".cursor"}, 20'(cursor), 20'(cur));
      chk({name, ".state"}, 20'(tmr_state), 20'(st));
      chk({name, ".expired"}, 20'(expired), 20'(ex));
      chk({name, ".ringing"}, 20'(ringing), 20'(ring));
   endtask

   task automatic step(input string name, input logic a, input logic tk, input logic g,
                       input logic [4:0] b, input logic [19:0] t, input logic [2:0] cur,
                       input logic [1:0] st, input logic ex, input logic ring);
      @(negedge clk_sys);
      active = a; tick_1hz = tk; start = g; button = b;
      @(posedge clk_sys);
      #1;
      tick_1hz = 1'b0; start = 1'b0; button = NB;
      check_all(name, t, cur, st, ex, ring);
   endtask

   task automatic add(input logic a, input logic tk, input logic g, input logic [4:0] b,
                      input logic [19:0] t, input logic [2:0] cur, input logic [1:0] st,
                      input logic ex, input logic ring);
      vec_t v;
      v.act = a; v.tick = tk; v.go = g; v.btn = b;
      v.t = t; v.cur = cur; v.st = st; v.ex = ex; v.ring = ring;
      vecs.push_back(v);
   endtask

   initial begin
      // Cursor and hour-digit basics, then a 3-second countdown to DONE.
      add(1, 0, 0, RT,  20'h40000 & 20'h0, 3'd5, 2'd0, 0, 0);
      add(1, 0, 0, UP,  20'h40000, 3'd5, 2'd0, 0, 0);
      add(1, 0, 0, LF,  20'h40000, 3'd0, 2'd0, 0, 0);
      add(1, 0, 0, RT,  20'h40000, 3'd5, 2'd0, 0, 0);
      add(1, 0, 0, DN,  20'h00000, 3'd5, 2'd0, 0, 0);
      add(1, 0, 0, LF,  20'h00000, 3'd0, 2'd0, 0, 0);
      add(1, 0, 1, NB,  20'h00000, 3'd0, 2'd0, 0, 0);
      add(0, 0, 0, UP,  20'h00000, 3'd0, 2'd0, 0, 0);
      add(1, 0, 0, MID, 20'h00000, 3'd0, 2'd0, 0, 0);
      add(1, 0, 0, UP,  20'h00001, 3'd0, 2'd0, 0, 0);
      add(1, 0, 0, UP,  20'h00002, 3'd0, 2'd0, 0, 0);
      add(1, 0, 0, UP,  20'h00003, 3'd0, 2'd0, 0, 0);
      add(1, 0, 1, NB,  20'h00003, 3'd0, 2'd1, 0, 0);
      add(1, 1, 0, NB,  20'h00002, 3'd0, 2'd1, 0, 0);
      add(1, 0, 0, NB,  20'h00002, 3'd0, 2'd1, 0, 0);
      add(1, 1, 0, NB,  20'h00001, 3'd0, 2'd1, 0, 0);
      add(1, 1, 0, NB,  20'h00000, 3'd0, 2'd3, 1, 1);
      add(1, 0, 0, NB,  20'h00000, 3'd0, 2'd3, 0, 1);
      add(1, 1, 0, NB,  20'h00000, 3'd0, 2'd3, 0, 1);
      add(1, 0, 1, NB,  20'h00003, 3'd0, 2'd0, 0, 0);
      // Preset 00:00:10, pause/resume and tick+start in RUN.
      add(1, 0, 0, DN,  20'h00002, 3'd0, 2'd0, 0, 0);
      add(1, 0, 0, DN,  20'h00001, 3'd0, 2'd0, 0, 0);
      add(1, 0, 0, DN,  20'h00000, 3'd0, 2'd0, 0, 0);
      add(1, 0, 0, LF,  20'h00000, 3'd1, 2'd0, 0, 0);
      add(1, 0, 0, UP,  20'h00010, 3'd1, 2'd0, 0, 0);
      add(1, 0, 1, NB,  20'h00010, 3'd0, 2'd1, 0, 0);
      add(1, 0, 1, NB,  20'h00010, 3'd0, 2'd2, 0, 0);
      for (int i = 0; i < 5; i++) add(1, 1, 0, NB, 20'h00010, 3'd0, 2'd2, 0, 0);
      add(1, 0, 1, NB,  20'h00010, 3'd0, 2'd1, 0, 0);
      add(1, 1, 0, NB,  20'h00009, 3'd0, 2'd1, 0, 0);
      add(1, 1, 1, NB,  20'h00008, 3'd0, 2'd2, 0, 0);
      add(1, 0, 1, NB,  20'h00008, 3'd0, 2'd1, 0, 0);
      // Inactive: start and buttons ignored, ticks still count.
      add(0, 0, 1, NB,  20'h00008, 3'd0, 2'd1, 0, 0);
      add(0, 0, 0, DN,  20'h00008, 3'd0, 2'd1, 0, 0);
      add(0, 1, 0, NB,  20'h00007, 3'd0, 2'd1, 0, 0);
      add(1, 0, 0, UP,  20'h00007, 3'd0, 2'd1, 0, 0);
      add(1, 1, 0, DN,  20'h00010, 3'd0, 2'd0, 0, 0);
      // Preset 00:00:01, tick and start together must expire rather than pause.
      add(1, 0, 0, LF,  20'h00010, 3'd1, 2'd0, 0, 0);
      add(1, 0, 0, DN,  20'h00000, 3'd1, 2'd0, 0, 0);
      add(1, 0, 0, RT,  20'h00000, 3'd0, 2'd0, 0, 0);
      add(1, 0, 0, UP,  20'h00001, 3'd0, 2'd0, 0, 0);
      add(1, 0, 1, NB,  20'h00001, 3'd0, 2'd1, 0, 0);
      add(1, 1, 1, NB,  20'h00000, 3'd0, 2'd3, 1, 1);
      add(1, 0, 1, NB,  20'h00001, 3'd0, 2'd0, 0, 0);

      rstn = 1'b0; tick_1hz = 1'b0; active = 1'b1; button = NB; start = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      check_all("reset", 20'h0, 3'd0, 2'd0, 1'b0, 1'b0);
      @(negedge clk_sys);
      rstn = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         step($sformatf("vec%0d", i), vecs[i].act, vecs[i].tick, vecs[i].go, vecs[i].btn,
              vecs[i].t, vecs[i].cur, vecs[i].st, vecs[i].ex, vecs[i].ring);

      // 01:00:00 -> 00:59:59 exercises the full borrow chain.
      step("brw_dn",    1, 0, 0, DN, 20'h00000, 3'd0, 2'd0, 0, 0);
      step("brw_rt5",   1, 0, 0, RT, 20'h00000, 3'd5, 2'd0, 0, 0);
      step("brw_rt4",   1, 0, 0, RT, 20'h00000, 3'd4, 2'd0, 0, 0);
      step("brw_up",    1, 0, 0, UP, 20'h04000, 3'd4, 2'd0, 0, 0);
      step("brw_start", 1, 0, 1, NB, 20'h04000, 3'd0, 2'd1, 0, 0);
      step("brw_tick",  1, 1, 0, NB, 20'h02CD9, 3'd0, 2'd1, 0, 0);
      step("brw_abort", 1, 0, 0, DN, 20'h04000, 3'd0, 2'd0, 0, 0);

      // Hour digit limits around 23 and the tens wrap with units above 3.
      step("hr_rt5",    1, 0, 0, RT, 20'h04000, 3'd5, 2'd0, 0, 0);
      step("hr_up11",   1, 0, 0, UP, 20'h44000, 3'd5, 2'd0, 0, 0);
      step("hr_up21",   1, 0, 0, UP, 20'h84000, 3'd5, 2'd0, 0, 0);
      step("hr_rt4",    1, 0, 0, RT, 20'h84000, 3'd4, 2'd0, 0, 0);
      step("hr_up22",   1, 0, 0, UP, 20'h88000, 3'd4, 2'd0, 0, 0);
      step("hr_up23",   1, 0, 0, UP, 20'h8C000, 3'd4, 2'd0, 0, 0);
      step("hr_up20",   1, 0, 0, UP, 20'h80000, 3'd4, 2'd0, 0, 0);
      step("hr_dn23",   1, 0, 0, DN, 20'h8C000, 3'd4, 2'd0, 0, 0);
      step("hr_lf5",    1, 0, 0, LF, 20'h8C000, 3'd5, 2'd0, 0, 0);
      step("hr_dn13",   1, 0, 0, DN, 20'h4C000, 3'd5, 2'd0, 0, 0);
      step("hr_dn03",   1, 0, 0, DN, 20'h0C000, 3'd5, 2'd0, 0, 0);
      step("hr_rt4b",   1, 0, 0, RT, 20'h0C000, 3'd4, 2'd0, 0, 0);
      step("hr_up04",   1, 0, 0, UP, 20'h10000, 3'd4, 2'd0, 0, 0);
      step("hr_lf5b",   1, 0, 0, LF, 20'h10000, 3'd5, 2'd0, 0, 0);
      step("hr_dn14",   1, 0, 0, DN, 20'h50000, 3'd5, 2'd0, 0, 0);
      step("hr_up04b",  1, 0, 0, UP, 20'h10000, 3'd5, 2'd0, 0, 0);

      // Reset while running clears every register on that edge.
      step("rst_start", 1, 0, 1, NB, 20'h10000, 3'd0, 2'd1, 0, 0);
      step("rst_tick",  1, 1, 0, NB, 20'h0ECD9, 3'd0, 2'd1, 0, 0);
      @(negedge clk_sys);
      rstn = 1'b0; tick_1hz = 1'b1;
      @(posedge clk_sys);
      #1;
      tick_1hz = 1'b0;
      check_all("rst_mid", 20'h0, 3'd0, 2'd0, 1'b0, 1'b0);
      @(negedge clk_sys);
      rstn = 1'b1;
      step("rst_idle",  1, 0, 0, NB, 20'h00000, 3'd0, 2'd0, 0, 0);
      step("rst_start0", 1, 0, 1, NB, 20'h00000, 3'd0, 2'd0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
